// File: rtl/pac_tile_renderer_pkg.sv
// Shared constants and types for the tile renderer and its controller.
// Direction encoding is common with control_pacman.
package pac_tile_renderer_pkg;

   localparam int TILE   = 5;
   localparam int MAX_TX = 26;
   localparam int MAX_TY = 23;

   localparam logic [2:0] FG_COLOUR = 3'b110;
   localparam logic [2:0] BG_COLOUR = 3'b000;
   localparam logic [2:0] LAST_RC   = 3'(TILE - 1);

   typedef enum logic [2:0] {
      DIR_RIGHT = 3'd0,
      DIR_UP    = 3'd1,
      DIR_LEFT  = 3'd2,
      DIR_DOWN  = 3'd3,
      DIR_WAIT  = 3'd4
   } dir_e;

   typedef enum logic [1:0] {
      IDLE,
      ERASE,
      DRAW,
      FINISH
   } state_e;

   typedef struct packed {
      logic [7:0] x;
      logic [6:0] y;
      logic [2:0] colour;
   } pixel_t;

   function automatic logic [4:0] bit_index(
      input logic [2:0] row,
      input logic [2:0] col
   );
      return 5'(int'(row) * TILE + int'(col));
   endfunction

endpackage

// File: rtl/pac_tile_renderer_if.sv
// Request/done handshake plus the VGA adapter pixel-plot port.
// slave = renderer side, master = controller / adapter side.
interface pac_tile_renderer_if;

   logic        draw_req;
   logic [7:0]  tile_x;
   logic [6:0]  tile_y;
   logic [24:0] shape;
   logic [7:0]  vga_x;
   logic [6:0]  vga_y;
   logic [2:0]  colour;
   logic        plot;
   logic        busy;
   logic        done;
   logic        req_err;

   modport slave (
      input  draw_req, tile_x, tile_y, shape,
      output vga_x, vga_y, colour, plot,
      output busy, done, req_err
   );

   modport master (
      output draw_req, tile_x, tile_y, shape,
      input  vga_x, vga_y, colour, plot,
      input  busy, done, req_err
   );

endinterface

// File: rtl/pac_tile_renderer_tile_pixel_walker.sv
// Row/col walker over one TILE x TILE sprite; exposes the next
// pixel position so the parent can register it directly.
module tile_pixel_walker
   import pac_tile_renderer_pkg::*;
(
   input  logic       clock,
   input  logic       reset_n,
   input  logic       start,
   input  logic       step,
   input  logic [7:0] base_tx,
   input  logic [6:0] base_ty,
   output logic [2:0] row_nx,
   output logic [2:0] col_nx,
   output logic [7:0] px_x,
   output logic [6:0] px_y,
   output logic       last
);

   logic [2:0] row_q, row_d;
   logic [2:0] col_q, col_d;

   always_comb begin
      row_d = row_q;
      col_d = col_q;
      if (start) begin
         row_d = '0;
         col_d = '0;
      end else if (step) begin
         if (col_q == LAST_RC) begin
            col_d = '0;
            row_d = row_q + 3'd1;
         end else begin
            col_d = col_q + 3'd1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         row_q <= '0;
         col_q <= '0;
      end else begin
         row_q <= row_d;
         col_q <= col_d;
      end
   end

   assign row_nx = row_d;
   assign col_nx = col_d;
   assign last   = (row_q == LAST_RC) && (col_q == LAST_RC);

   // Fits in 8/7 bits for every legal tile (max 134 / 119).
   assign px_x = base_tx * 8'(TILE) + 8'(col_d);
   assign px_y = base_ty * 7'(TILE) + 7'(row_d);

endmodule

// File: rtl/pac_tile_renderer.sv
// Erases the previous sprite footprint then paints the new 5x5
// sprite, one registered VGA plot per clock.
module pac_tile_renderer
   import pac_tile_renderer_pkg::*;
(
   input logic                 clock,
   input logic                 reset_n,
   pac_tile_renderer_if.slave  bus
);

   state_e      state_q, state_d;
   logic [7:0]  new_x_q, new_x_d;
   logic [6:0]  new_y_q, new_y_d;
   logic [24:0] new_shape_q, new_shape_d;
   logic [7:0]  prev_x_q, prev_x_d;
   logic [6:0]  prev_y_q, prev_y_d;
   logic        has_prev_q, has_prev_d;

   logic [7:0]  vga_x_q, vga_x_d;
   logic [6:0]  vga_y_q, vga_y_d;
   logic [2:0]  colour_q, colour_d;
   logic        plot_q, plot_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        req_err_q, req_err_d;

   logic        w_start, w_step, w_last;
   logic [7:0]  w_base_x, w_px_x;
   logic [6:0]  w_base_y, w_px_y;
   logic [2:0]  w_row, w_col;
   logic        in_range;

   assign in_range = (bus.tile_x <= 8'(MAX_TX))
                  && (bus.tile_y <= 7'(MAX_TY));

   always_comb begin
      state_d     = state_q;
      new_x_d     = new_x_q;
      new_y_d     = new_y_q;
      new_shape_d = new_shape_q;
      prev_x_d    = prev_x_q;
      prev_y_d    = prev_y_q;
      has_prev_d  = has_prev_q;
      req_err_d   = 1'b0;
      w_start     = 1'b0;
      w_step      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.draw_req) begin
               if (in_range) begin
                  new_x_d     = bus.tile_x;
                  new_y_d     = bus.tile_y;
                  new_shape_d = bus.shape;
                  w_start     = 1'b1;
                  state_d     = has_prev_q ? ERASE : DRAW;
               end else begin
                  req_err_d = 1'b1;
               end
            end
         end
         ERASE: begin
            if (w_last) begin
               w_start = 1'b1;
               state_d = DRAW;
            end else begin
               w_step = 1'b1;
            end
         end
         DRAW: begin
            if (w_last) state_d = FINISH;
            else        w_step  = 1'b1;
         end
         FINISH: begin
            prev_x_d   = new_x_q;
            prev_y_d   = new_y_q;
            has_prev_d = 1'b1;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs are registered from next-state values so the first
   // pixel appears in the cycle right after acceptance.
   always_comb begin
      w_base_x = (state_d == ERASE) ? prev_x_q : new_x_d;
      w_base_y = (state_d == ERASE) ? prev_y_q : new_y_d;
      plot_d   = (state_d == ERASE) || (state_d == DRAW);
      busy_d   = plot_d;
      done_d   = (state_d == FINISH);
      vga_x_d  = vga_x_q;
      vga_y_d  = vga_y_q;
      colour_d = BG_COLOUR;
      if (plot_d) begin
         vga_x_d = w_px_x;
         vga_y_d = w_px_y;
      end
      if (state_d == DRAW &&
          new_shape_d[bit_index(w_row, w_col)]) begin
         colour_d = FG_COLOUR;
      end
   end

   tile_pixel_walker u_walker (
      .clock   (clock),
      .reset_n (reset_n),
      .start   (w_start),
      .step    (w_step),
      .base_tx (w_base_x),
      .base_ty (w_base_y),
      .row_nx  (w_row),
      .col_nx  (w_col),
      .px_x    (w_px_x),
      .px_y    (w_px_y),
      .last    (w_last)
   );

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         new_x_q     <= '0;
         new_y_q     <= '0;
         new_shape_q <= '0;
         prev_x_q    <= '0;
         prev_y_q    <= '0;
         has_prev_q  <= 1'b0;
         vga_x_q     <= '0;
         vga_y_q     <= '0;
         colour_q    <= BG_COLOUR;
         plot_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         req_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         new_x_q     <= new_x_d;
         new_y_q     <= new_y_d;
         new_shape_q <= new_shape_d;
         prev_x_q    <= prev_x_d;
         prev_y_q    <= prev_y_d;
         has_prev_q  <= has_prev_d;
         vga_x_q     <= vga_x_d;
         vga_y_q     <= vga_y_d;
         colour_q    <= colour_d;
         plot_q      <= plot_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         req_err_q   <= req_err_d;
      end
   end

   assign bus.vga_x   = vga_x_q;
   assign bus.vga_y   = vga_y_q;
   assign bus.colour  = colour_q;
   assign bus.plot    = plot_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.req_err = req_err_q;

endmodule

// File: tb/tb_pac_tile_renderer.sv
// Scoreboard bench for pac_tile_renderer: stimulus queues expected
// plots and done cycles, a negedge monitor pops and compares.
module tb_pac_tile_renderer;
   import pac_tile_renderer_pkg::*;

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   pac_tile_renderer_if bus();

   pac_tile_renderer dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int cyc = 0;
   always @(posedge clock) cyc++;

   pixel_t exp_q[$];
   int     done_exp_q[$];
   int     errors = 0;
   int     checks = 0;
   int     done_cnt = 0;

   logic       m_has = 1'b0;
   logic [7:0] m_px = '0;
   logic [6:0] m_py = '0;

   task automatic check(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   always @(negedge clock) begin
      pixel_t e;
      if (bus.plot === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL plot_unexpected: got (%0d,%0d,%0d) none expected",
                     bus.vga_x, bus.vga_y, bus.colour);
         end else begin
            e = exp_q.pop_front();
            if (bus.vga_x !== e.x || bus.vga_y !== e.y ||
                bus.colour !== e.colour) begin
               errors++;
               $display("FAIL pixel: got (%0d,%0d,%0d) expected (%0d,%0d,%0d)",
                        bus.vga_x, bus.vga_y, bus.colour,
                        e.x, e.y, e.colour);
            end
         end
      end
      if (bus.done === 1'b1) begin
         done_cnt++;
         checks++;
         if (done_exp_q.size() == 0) begin
            errors++;
            $display("FAIL done_unexpected: got done at %0d none expected",
                     cyc);
         end else begin
            int d;
            d = done_exp_q.pop_front();
            if (d != cyc) begin
               errors++;
               $display("FAIL done_cycle: got %0d expected %0d", cyc, d);
            end
         end
         check("busy_at_done", int'(bus.busy), 0);
      end
   end

   task automatic push_render(
      input logic [7:0] tx, input logic [6:0] ty, input logic [24:0] shp
   );
      pixel_t p;
      if (m_has) begin
         for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++) begin
               p.x = 8'(int'(m_px) * 5 + c);
               p.y = 7'(int'(m_py) * 5 + r);
               p.colour = 3'b000;
               exp_q.push_back(p);
            end
      end
      for (int r = 0; r < 5; r++)
         for (int c = 0; c < 5; c++) begin
            p.x = 8'(int'(tx) * 5 + c);
            p.y = 7'(int'(ty) * 5 + r);
            p.colour = shp[r * 5 + c] ? 3'b110 : 3'b000;
            exp_q.push_back(p);
         end
      m_has = 1'b1;
      m_px = tx;
      m_py = ty;
   endtask

   task automatic start_render(
      input logic [7:0] tx, input logic [6:0] ty,
      input logic [24:0] shp, input bit abort, output int acc
   );
      int lat;
      @(negedge clock);
      acc = cyc + 1;
      lat = m_has ? 50 : 25;
      push_render(tx, ty, shp);
      if (!abort) done_exp_q.push_back(acc + lat);
      bus.tile_x = tx;
      bus.tile_y = ty;
      bus.shape = shp;
      bus.draw_req = 1'b1;
      @(negedge clock);
      bus.draw_req = 1'b0;
      #1;
      check("busy_cycle1", int'(bus.busy), 1);
   endtask

   task automatic wait_done(input int acc, input bit poke);
      int d0;
      int rel;
      bit seen;
      d0 = done_cnt;
      seen = 1'b0;
      for (int i = 0; i < 120 && !seen; i++) begin
         @(negedge clock);
         #1;
         rel = cyc - acc + 1;
         bus.draw_req = poke && (rel == 5 || rel == 30);
         if (poke) begin
            bus.tile_x = 8'd0;
            bus.tile_y = 7'd0;
            bus.shape = 25'h1FFFFFF;
         end
         if (done_cnt > d0) seen = 1'b1;
      end
      bus.draw_req = 1'b0;
      check("done_seen", int'(seen), 1);
      repeat (3) @(negedge clock);
      #1;
      check("done_count", done_cnt - d0, 1);
      check("plots_left", exp_q.size(), 0);
   endtask

   task automatic bad_req(input logic [7:0] tx, input logic [6:0] ty);
      @(negedge clock);
      bus.tile_x = tx;
      bus.tile_y = ty;
      bus.draw_req = 1'b1;
      @(negedge clock);
      bus.draw_req = 1'b0;
      #1;
      check("req_err_pulse", int'(bus.req_err), 1);
      check("req_err_busy", int'(bus.busy), 0);
      check("req_err_plot", int'(bus.plot), 0);
      @(negedge clock);
      #1;
      check("req_err_clear", int'(bus.req_err), 0);
   endtask

   initial begin
      int acc;
      bus.draw_req = 1'b0;
      bus.tile_x = '0;
      bus.tile_y = '0;
      bus.shape = '0;
      repeat (3) @(negedge clock);
      #1;
      check("rst_plot", int'(bus.plot), 0);
      check("rst_busy", int'(bus.busy), 0);
      check("rst_done", int'(bus.done), 0);
      check("rst_req_err", int'(bus.req_err), 0);
      check("rst_vga_x", int'(bus.vga_x), 0);
      check("rst_vga_y", int'(bus.vga_y), 0);
      check("rst_colour", int'(bus.colour), 0);
      reset_n = 1'b1;

      start_render(8'd0, 7'd0, 25'h1FFFFFF, 1'b0, acc);
      wait_done(acc, 1'b0);

      start_render(8'd26, 7'd23, 25'h0000001, 1'b0, acc);
      wait_done(acc, 1'b0);

      bad_req(8'd27, 7'd5);
      bad_req(8'd0, 7'd24);
      start_render(8'd10, 7'd4, 25'h1555555, 1'b0, acc);
      wait_done(acc, 1'b0);

      start_render(8'd5, 7'd5, 25'h0F0F0F0, 1'b0, acc);
      wait_done(acc, 1'b1);

      start_render(8'd1, 7'd1, 25'h000F00F, 1'b1, acc);
      repeat (14) void'(exp_q.pop_back());
      while (cyc - acc + 1 < 36) @(negedge clock);
      #1;
      reset_n = 1'b0;
      m_has = 1'b0;
      @(negedge clock);
      #1;
      check("rstmid_plot", int'(bus.plot), 0);
      check("rstmid_busy", int'(bus.busy), 0);
      check("rstmid_vga_x", int'(bus.vga_x), 0);
      check("rstmid_vga_y", int'(bus.vga_y), 0);
      check("rstmid_colour", int'(bus.colour), 0);
      check("rstmid_left", exp_q.size(), 0);
      reset_n = 1'b1;

      start_render(8'd3, 7'd2, 25'h1084210, 1'b0, acc);
      wait_done(acc, 1'b0);

      check("done_queue_left", done_exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
